// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, request encodings and controller state/port types
package mem_ctrl_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam logic [1:0] RW_READ = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic {PORT_IF, PORT_LS} port_t;
endpackage

// File: rtl/mem_ctrl_port_latch.sv
// mem_port_latch: holds one port's request pulse (rw_flag/addr/len/wdata in; req/req_* out) until granted, ignoring pulses while pending or active
module mem_port_latch
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [1:0]        rw_flag,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        len,
  input  logic [DATA_W-1:0] wdata,
  input  logic              active,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] req_addr,
  output logic [1:0]        req_len,
  output logic [DATA_W-1:0] req_wdata,
  output logic              req_write
);
  logic valid, p_write, pulse;
  logic [ADDR_W-1:0] p_addr;
  logic [1:0] p_len;
  logic [DATA_W-1:0] p_wdata;
  assign pulse = |rw_flag && !active;
  assign req = valid || pulse;
  assign req_addr = valid ? p_addr : addr;
  assign req_len = valid ? p_len : len;
  assign req_wdata = valid ? p_wdata : wdata;
  assign req_write = valid ? p_write : |(rw_flag & RW_WRITE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      p_write <= 1'b0;
      p_addr <= '0;
      p_len <= '0;
      p_wdata <= '0;
    end else if (rdy) begin
      if (grant) valid <= 1'b0;
      else if (pulse && !valid) begin
        valid <= 1'b1;
        p_write <= |(rw_flag & RW_WRITE);
        p_addr <= addr;
        p_len <= len;
        p_wdata <= wdata;
      end
    end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates fetch (if_*) and load/store (ls_*) requests onto a byte-wide sync RAM (ram_*), LS first, little-endian 1..4 byte transfers
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [1:0]        if_rw_flag,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [1:0]        if_len,
  output logic [DATA_W-1:0] if_read_data,
  output logic              if_busy,
  output logic              if_done,
  input  logic [1:0]        ls_rw_flag,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [1:0]        ls_len,
  input  logic [DATA_W-1:0] ls_write_data,
  output logic [DATA_W-1:0] ls_read_data,
  output logic              ls_busy,
  output logic              ls_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);
  state_t state, state_nxt;
  port_t owner;
  logic [ADDR_W-1:0] x_addr, if_a, ls_a;
  logic [1:0] x_len, cnt, cap_k, if_l, ls_l;
  logic [DATA_W-1:0] x_wdata, asm, asm_nxt, if_wd, ls_wd;
  logic tail, if_req, ls_req, if_w, ls_w, start, xfer, cap, finish_rd;
  mem_port_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_if (
    .clk(clk), .rst(rst), .rdy(rdy), .rw_flag(if_rw_flag), .addr(if_addr), .len(if_len),
    .wdata('0), .active(xfer && owner == PORT_IF), .grant(start && !ls_req),
    .req(if_req), .req_addr(if_a), .req_len(if_l), .req_wdata(if_wd), .req_write(if_w)
  );
  mem_port_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ls (
    .clk(clk), .rst(rst), .rdy(rdy), .rw_flag(ls_rw_flag), .addr(ls_addr), .len(ls_len),
    .wdata(ls_write_data), .active(xfer && owner == PORT_LS), .grant(start && ls_req),
    .req(ls_req), .req_addr(ls_a), .req_len(ls_l), .req_wdata(ls_wd), .req_write(ls_w)
  );
  assign start = (state == IDLE || state == DONE) && (if_req || ls_req);
  assign xfer = state == READ || state == WRITE;
  // tail is the extra READ cycle that only captures the last byte; cnt-1 indexes the byte whose data is on ram_din
  assign cap = state == READ && (tail || cnt != 2'd0);
  assign cap_k = cnt - 2'd1;
  assign finish_rd = state == READ && tail;
  always_comb begin
    asm_nxt = asm;
    if (cap) asm_nxt[8*cap_k +: 8] = ram_din;
  end
  always_comb begin
    state_nxt = start ? ((ls_req ? ls_w : if_w) ? WRITE : READ)
      : state == DONE ? IDLE
      : state == WRITE && cnt == x_len ? DONE
      : finish_rd ? DONE
      : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      owner <= PORT_IF;
      x_addr <= '0;
      x_len <= '0;
      x_wdata <= '0;
      cnt <= '0;
      tail <= 1'b0;
      asm <= '0;
      if_read_data <= '0;
      ls_read_data <= '0;
    end else if (rdy) begin
      state <= state_nxt;
      cnt <= xfer ? cnt + 2'd1 : 2'd0;
      tail <= state == READ && !tail && cnt == x_len;
      asm <= start ? '0 : asm_nxt;
      owner <= start ? (ls_req ? PORT_LS : PORT_IF) : owner;
      x_addr <= start ? (ls_req ? ls_a : if_a) : x_addr;
      x_len <= start ? (ls_req ? ls_l : if_l) : x_len;
      x_wdata <= start ? (ls_req ? ls_wd : if_wd) : x_wdata;
      if_read_data <= finish_rd && owner == PORT_IF ? asm_nxt : if_read_data;
      ls_read_data <= finish_rd && owner == PORT_LS ? asm_nxt : ls_read_data;
    end
  assign ram_a = state == WRITE || (state == READ && !tail) ? x_addr + ADDR_W'(cnt) : '0;
  assign ram_wr = state == WRITE && rdy;
  assign ram_dout = state == WRITE ? x_wdata[8*cnt +: 8] : '0;
  assign if_busy = state != IDLE;
  assign ls_busy = state != IDLE;
  assign if_done = state == DONE && owner == PORT_IF;
  assign ls_done = state == DONE && owner == PORT_LS;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a registered-read byte RAM model
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  logic clk = 0, rst = 1, rdy = 1, init = 1;
  logic [1:0] if_rw_flag = 0, if_len = 0, ls_rw_flag = 0, ls_len = 0;
  logic [31:0] if_addr = 0, ls_addr = 0, ls_write_data = 0;
  logic [31:0] if_read_data, ls_read_data, ram_a;
  logic if_busy, if_done, ls_busy, ls_done, ram_wr;
  logic [7:0] ram_din = 0, ram_dout;
  logic [7:0] mem [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic [32:0] if_q[$], ls_q[$];
  logic [39:0] wr_q[$];
  logic [32:0] mon_e;
  int checks = 0, failures = 0, wr_count = 0, cyc = 0, n0 = 0, ls_at = 0;
  always #5 clk = ~clk;
  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_rw_flag(if_rw_flag), .if_addr(if_addr), .if_len(if_len),
    .if_read_data(if_read_data), .if_busy(if_busy), .if_done(if_done),
    .ls_rw_flag(ls_rw_flag), .ls_addr(ls_addr), .ls_len(ls_len), .ls_write_data(ls_write_data),
    .ls_read_data(ls_read_data), .ls_busy(ls_busy), .ls_done(ls_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
  );
  function automatic logic [7:0] init_byte(input int a);
    case (a)
      'h100: return 8'h13;
      'h101, 'h102: return 8'h00;
      'h103: return 8'h93;
      default: return 8'(a * 7 + 3);
    endcase
  endfunction
  always @(posedge clk) begin
    if (init && rst) for (int i = 0; i < 4096; i++) mem[i] <= init_byte(i);
    else if (ram_wr) begin
      mem[ram_a[11:0]] <= ram_dout;
      wr_count <= wr_count + 1;
    end
    ram_din <= mem[ram_a[11:0]];
    cyc <= cyc + 1;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    if_rw_flag = 0;
    ls_rw_flag = 0;
  endtask
  function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] l);
    logic [31:0] d = '0;
    for (int k = 0; k <= int'(l); k++) d[8*k +: 8] = ref_mem[12'(a + 32'(k))];
    return d;
  endfunction
  task automatic if_req(input logic [31:0] a, input logic [1:0] l);
    if_rw_flag = RW_READ;
    if_addr = a;
    if_len = l;
    if_q.push_back({1'b1, ref_read(a, l)});
  endtask
  task automatic ls_req(input logic [1:0] f, input logic [31:0] a, input logic [1:0] l, input logic [31:0] wd);
    ls_rw_flag = f;
    ls_addr = a;
    ls_len = l;
    ls_write_data = wd;
    if (f[1]) begin
      for (int k = 0; k <= int'(l); k++) begin
        wr_q.push_back({a + 32'(k), wd[8*k +: 8]});
        ref_mem[12'(a + 32'(k))] = wd[8*k +: 8];
      end
      ls_q.push_back(33'h0);
    end else ls_q.push_back({1'b1, ref_read(a, l)});
  endtask
  task automatic wait_done(input logic ls, input string tag);
    int n = 0;
    do begin
      step;
      n++;
    end while (!(ls ? ls_done : if_done) && n < 40);
    check({tag, "_timeout"}, 64'(n < 40), 1);
  endtask
  always @(negedge clk) if (!rst) begin
    if (if_done) begin
      check("if_done_expected", 64'(if_q.size() != 0), 1);
      if (if_q.size() != 0) begin
        mon_e = if_q.pop_front();
        if (mon_e[32]) check("if_rdata", if_read_data, mon_e[31:0]);
      end
    end
    if (ls_done) begin
      check("ls_done_expected", 64'(ls_q.size() != 0), 1);
      if (ls_q.size() != 0) begin
        mon_e = ls_q.pop_front();
        if (mon_e[32]) check("ls_rdata", ls_read_data, mon_e[31:0]);
      end
    end
    if (ram_wr) begin
      check("wr_expected", 64'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) check("wr_byte", {ram_a, ram_dout}, wr_q.pop_front());
    end
  end
  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {if_busy, ls_busy, if_done, ls_done, ram_wr}, 0);
    check("rst_ram", {ram_a, ram_dout}, 0);
    check("rst_rdata", {if_read_data, ls_read_data}, 0);
    rst = 0;
    init = 0;
    step;
    if_req(32'h100, 2'd3);
    step;
    clr;
    for (int k = 0; k < 4; k++) begin
      check("t1_ram_a", ram_a, 32'h100 + k);
      check("t1_no_wr", {ram_wr, if_done}, 0);
      if (k == 1) begin
        if_rw_flag = RW_READ;
        if_addr = 32'h500;
      end
      step;
      clr;
    end
    check("t1_tail_no_done", {if_done, ram_a}, 0);
    step;
    check("t1_done", if_done, 1);
    check("t1_rdata", if_read_data, 32'h93000013);
    step;
    check("t1_idle_after", {if_busy, if_done}, 0);
    n0 = wr_count;
    ls_req(RW_WRITE, 32'h20, 2'd1, 32'hBEEF);
    step;
    clr;
    check("t2_wr0", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h20, 8'hEF});
    step;
    check("t2_wr1", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h21, 8'hBE});
    step;
    check("t2_done", {ls_done, ram_wr}, 2'b10);
    repeat (3) step;
    check("t2_count", 64'(wr_count - n0), 2);
    ls_req(RW_READ, 32'h20, 2'd1, 0);
    step;
    clr;
    wait_done(1, "t2r");
    check("t2_zext", ls_read_data, 32'h0000BEEF);
    ls_req(RW_WRITE, 32'h300, 2'd3, 32'hCAFEF00D);
    if_req(32'h100, 2'd3);
    step;
    clr;
    check("t3_ls_first", ram_a, 32'h300);
    wait_done(1, "t3_ls");
    ls_at = cyc;
    step;
    check("t3_if_start", {ram_wr, ram_a}, {1'b0, 32'h100});
    wait_done(0, "t3_if");
    check("t3_gap", 64'(cyc - ls_at), 6);
    check("t3_rdata", if_read_data, 32'h93000013);
    if_req(32'h104, 2'd3);
    step;
    clr;
    wait_done(0, "t4_a");
    if_req(32'h108, 2'd1);
    step;
    clr;
    check("t4_b_start", ram_a, 32'h108);
    wait_done(0, "t4_b");
    check("t4_b_rdata", if_read_data, ref_read(32'h108, 2'd1));
    n0 = wr_count;
    ls_req(RW_WRITE, 32'h40, 2'd3, 32'h11223344);
    step;
    clr;
    check("t5_wr0", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h40, 8'h44});
    step;
    rdy = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("t5_frozen", {ram_wr, ram_a, ram_dout}, {1'b0, 32'h41, 8'h33});
      step;
    end
    rdy = 1;
    #1;
    check("t5_resume", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h41, 8'h33});
    step;
    check("t5_wr2", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h42, 8'h22});
    step;
    check("t5_wr3", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h43, 8'h11});
    step;
    check("t5_done", ls_done, 1);
    check("t5_count", 64'(wr_count - n0), 4);
    ls_req(RW_READ, 32'h40, 2'd3, 0);
    step;
    clr;
    wait_done(1, "t5r");
    check("t5_readback", ls_read_data, 32'h11223344);
    ls_req(RW_READ, 32'hFFFF_FFFF, 2'd1, 0);
    step;
    clr;
    check("wrap_a0", ram_a, 32'hFFFF_FFFF);
    step;
    check("wrap_a1", ram_a, 32'h0);
    wait_done(1, "wrap");
    check("wrap_rdata", ls_read_data, {16'h0, init_byte(0), init_byte(4095)});
    ls_req(2'b11, 32'h50, 2'd0, 32'h123456A5);
    step;
    clr;
    check("rw11_write", {ram_wr, ram_a, ram_dout}, {1'b1, 32'h50, 8'hA5});
    wait_done(1, "rw11");
    if_req(32'h100, 2'd3);
    step;
    clr;
    step;
    rst = 1;
    #1;
    check("t6_rst_flags", {if_busy, ls_busy, if_done, ram_wr}, 0);
    check("t6_rst_ram", {ram_a, ram_dout}, 0);
    check("t6_rst_rdata", if_read_data, 0);
    if_q.delete();
    repeat (2) step;
    rst = 0;
    repeat (8) step;
    check("t6_idle", if_busy, 0);
    if_req(32'h100, 2'd3);
    step;
    clr;
    wait_done(0, "t6_fresh");
    check("t6_rdata", if_read_data, 32'h93000013);
    repeat (3) step;
    check("if_q_drained", 64'(if_q.size()), 0);
    check("ls_q_drained", 64'(ls_q.size()), 0);
    check("wr_q_drained", 64'(wr_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
